ahb_slave_mem: RTL and testbench
================================

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning data-phase wait cycles per OKAY transfer (legal 0-7).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning start of the decoded region (64 bytes = 16 words).
REQ-003 SHALL have port HCLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Hwrite  input  1  1=write, 0=read (address phase).
REQ-006 SHALL have port Hreadyin  input  1  bus-ready from the previous transfer; address phase is sampled only when high.
REQ-007 SHALL have port Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 SHALL have port Haddr  input  32  byte address (address phase).
REQ-009 SHALL have port Hwdata  input  32  write data (data phase).
REQ-010 SHALL have port Hreadyout  output  1  0 = extend the current data phase.
REQ-011 SHALL have port Hresp  output  2  00 OKAY, 01 ERROR; 10/11 are never driven.
REQ-012 SHALL have port Hrdata  output  32  read data (data phase).

Function
REQ-013 SHALL treat a transfer as valid when, at a rising edge: Hreadyin=1, Hreadyout=1, and Htrans is 10 or 11.
REQ-014 SHALL respond to IDLE/BUSY or Hreadyin=0 with zero-wait OKAY and no storage side effect.
REQ-015 SHALL flag a valid transfer as bad if Haddr is outside [BASE_ADDR, BASE_ADDR+63] or Haddr[1:0]!=0.
REQ-016 SHALL register Haddr[5:2], Hwrite and the bad flag at the address-phase edge, for use in the data phase.
REQ-017 SHALL implement the state machine IDLE, WAIT, DATA, ERR1, ERR2, with all outputs registered.
REQ-018 In IDLE/DATA/ERR2, a valid good transfer SHALL go to WAIT if WAIT_STATES>0, else to DATA.
REQ-019 In IDLE/DATA/ERR2, a valid bad transfer SHALL go to ERR1.
REQ-020 In IDLE/DATA/ERR2, when no valid transfer is present, the next state SHALL be IDLE.
REQ-021 WAIT SHALL hold Hreadyout=0, Hresp=00, and count WAIT_STATES cycles via a 3-bit counter, then go to DATA.
REQ-022 DATA SHALL drive Hreadyout=1 and Hresp=00 for exactly one cycle.
REQ-023 ERR1 SHALL drive Hreadyout=0 and Hresp=01 for one cycle, then go to ERR2.
REQ-024 ERR2 SHALL drive Hreadyout=1 and Hresp=01 for one cycle.
REQ-025 SHALL ignore address-phase inputs while Hreadyout=0 (WAIT, ERR1).
REQ-026 Write: SHALL store Hwdata into mem[index] at the edge ending the DATA cycle.
REQ-027 Bad or aborted transfers SHALL never write.
REQ-028 Read: Hrdata SHALL equal mem[index] throughout the DATA cycle and SHALL be 0 in all other states.
REQ-029 Storage SHALL be 16 x 32-bit words, indexed by Haddr[5:2].
REQ-030 Read-after-write to the same index in back-to-back transfers, including WAIT_STATES=0, SHALL return the newly written data via forwarding.
REQ-031 Back-to-back pipelined transfers SHALL be accepted on the DATA/ERR2 completion edge with no idle cycle inserted.

Reset
REQ-032 On HRESET=1 at a rising edge, state SHALL be IDLE, Hreadyout=1, Hresp=00, Hrdata=0, wait counter=0, and all 16 words=0.
REQ-033 Reset mid-transfer (WAIT/DATA/ERR1) SHALL abort it with no write, and SHALL return to IDLE outputs at the next edge.
REQ-034 HRESET SHALL take priority over all other inputs.

Verification
REQ-035 Write: NONSEQ, Hwrite=1, Haddr=32'h8000_0004, then Hwdata=32'h1231_4532, WAIT_STATES=1 -> Hreadyout 0 for one cycle, then 1 with Hresp=00; mem[1]=32'h1231_4532.
REQ-036 Readback: NONSEQ read of 32'h8000_0004 -> after one wait cycle, Hrdata=32'h1231_4532 with Hreadyout=1 and Hresp=00.
REQ-037 Misaligned: NONSEQ write to 32'h8000_0001 -> Hresp=01 with Hreadyout=0, then Hresp=01 with Hreadyout=1; no memory change.
REQ-038 Out of range: read of 32'h4000_0000 -> two-cycle ERROR as in REQ-037; Hrdata=0.
REQ-039 With WAIT_STATES=0, back-to-back write of 32'hA5A5_0001 to 32'h8000_0008 then read of 32'h8000_0008 -> Hreadyout stays 1 and the read returns 32'hA5A5_0001.
REQ-040 IDLE/Hreadyin=0 and reset: Htrans=00 or Hreadyin=0 -> Hreadyout=1, Hresp=00, no write; HRESET asserted during WAIT of a write -> IDLE outputs next cycle and target word stays 0.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a 16 x 32-bit register file with configurable data-phase wait states.
// Every bus output is registered; the next-state logic also computes the next output values.
module ahb_slave_mem #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Final count value of the WAIT state; unused when WAIT_STATES is 0.
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

  logic [2:0]  state, state_n;
  logic [2:0]  wait_cnt, wait_cnt_n;
  logic [3:0]  addr_q, addr_n;
  logic        wr_q, wr_n;
  logic        bad_q, bad_n;
  logic [31:0] mem [16];

  logic        valid;
  logic        bad;
  logic [31:0] offset;
  logic        data_write;
  logic        load_rd;
  logic [3:0]  rd_idx;
  logic [31:0] rdata_n;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    valid      = Hreadyin && Hreadyout && Htrans[1];
    offset     = Haddr - BASE_ADDR;
    bad        = (Haddr < BASE_ADDR) || (offset > 32'd63) || (Haddr[1:0] != 2'b00);
    data_write = (state == S_DATA) && wr_q && !bad_q;

    state_n    = state;
    wait_cnt_n = wait_cnt;
    addr_n     = addr_q;
    wr_n       = wr_q;
    bad_n      = bad_q;
    load_rd    = 1'b0;
    rd_idx     = addr_q;

    case (state)
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_n = S_DATA;
          load_rd = !wr_q;
        end else begin
          wait_cnt_n = wait_cnt + 3'd1;
        end
      end
      S_ERR1: state_n = S_ERR2;
      S_IDLE, S_DATA, S_ERR2: begin
        if (valid) begin
          addr_n     = Haddr[5:2];
          wr_n       = Hwrite;
          bad_n      = bad;
          wait_cnt_n = 3'd0;
          if (bad) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
          end else begin
            state_n = S_DATA;
            load_rd = !Hwrite;
            rd_idx  = Haddr[5:2];
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A read entering DATA on the same edge that a write to its word retires sees the new data.
    rdata_n = '0;
    if (load_rd) begin
      rdata_n = (data_write && (addr_q == rd_idx)) ? Hwdata : mem[rd_idx];
    end
  end

  // NOTE: the storage is small enough to live in flops, so it is cleared with the rest of the state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      wait_cnt  <= 3'd0;
      addr_q    <= 4'd0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      Hreadyout <= 1'b1;
      Hresp     <= RESP_OKAY;
      Hrdata    <= '0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      addr_q    <= addr_n;
      wr_q      <= wr_n;
      bad_q     <= bad_n;
      Hreadyout <= (state_n == S_IDLE) || (state_n == S_DATA) || (state_n == S_ERR2);
      Hresp     <= ((state_n == S_ERR1) || (state_n == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
      Hrdata    <= rdata_n;
      if (data_write) begin
        mem[addr_q] <= Hwdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a cycle-by-cycle vector table on a one-wait-state instance,
// plus hand-written zero-wait forwarding and reset-abort sequences.
module tb_ahb_slave_mem;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef struct packed {
    logic        hreadyin;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        exp_ready;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b1;
  logic [1:0]  Htrans = T_IDLE;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;

  logic        ready1, ready0;
  logic [1:0]  resp1, resp0;
  logic [31:0] rdata1, rdata0;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs[$];

  ahb_slave_mem #(.WAIT_STATES(1), .BASE_ADDR(32'h8000_0000)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(ready1), .Hresp(resp1), .Hrdata(rdata1)
  );

  ahb_slave_mem #(.WAIT_STATES(0), .BASE_ADDR(32'h8000_0000)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(ready0), .Hresp(resp0), .Hrdata(rdata0)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_bus(input string name, input bit zero_wait, input logic exp_ready,
                           input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
    check({name, ".ready"}, zero_wait ? 32'(ready0) : 32'(ready1), 32'(exp_ready));
    check({name, ".resp"},  zero_wait ? 32'(resp0)  : 32'(resp1),  32'(exp_resp));
    check({name, ".rdata"}, zero_wait ? rdata0      : rdata1,      exp_rdata);
  endtask

  task automatic drive(input logic rdyin, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    Hreadyin = rdyin;
    Htrans   = trans;
    Hwrite   = wr;
    Haddr    = addr;
    Hwdata   = wd;
  endtask

  // Advance one clock and settle past the edge before outputs are sampled.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'h0);
    step();
    step();
    HRESET = 1'b0;
  endtask

  initial begin
    // Each row: inputs held for one cycle, then the registered outputs expected after that edge.
    vecs.push_back('{1'b1, T_NONSEQ, 1'b1, 32'h8000_0004, 32'h0,          1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h1231_4532,  1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b0, 32'h8000_0004, 32'h1231_4532,  1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b00, 32'h1231_4532});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b1, 32'h8000_0000, 32'h0,          1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'hDEAD_BEEF,  1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b1, 32'h8000_0001, 32'hDEAD_BEEF,  1'b0, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h5555_5555,  1'b1, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b0, 32'h4000_0000, 32'h5555_5555,  1'b0, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b0, 32'h8000_0000, 32'h0,          1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b00, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b1, 32'h8000_003C, 32'h0,          1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0BAD_F00D,  1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b1, 32'h8000_0040, 32'h0BAD_F00D,  1'b0, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_BUSY,   1'b0, 32'h8000_003C, 32'h0,          1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b0, T_NONSEQ, 1'b0, 32'h8000_003C, 32'h0,          1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_SEQ,    1'b0, 32'h8000_003C, 32'h0,          1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b00, 32'h0BAD_F00D});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b0, 32'h7FFF_FFFC, 32'h0,          1'b0, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b01, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b1, 32'h8000_0000, 32'h1111_1111,  1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b0, T_NONSEQ, 1'b1, 32'h8000_0000, 32'h2222_2222,  1'b1, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_NONSEQ, 1'b0, 32'h8000_0000, 32'h3333_3333,  1'b0, 2'b00, 32'h0});
    vecs.push_back('{1'b1, T_IDLE,   1'b0, 32'h0,         32'h0,          1'b1, 2'b00, 32'hDEAD_BEEF});

    do_reset();
    check_bus("reset_ws1", 1'b0, 1'b1, 2'b00, 32'h0);
    check_bus("reset_ws0", 1'b1, 1'b1, 2'b00, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].hreadyin, vecs[i].htrans, vecs[i].hwrite, vecs[i].haddr, vecs[i].hwdata);
      step();
      check_bus($sformatf("vec%0d", i), 1'b0, vecs[i].exp_ready, vecs[i].exp_resp, vecs[i].exp_rdata);
    end

    // Zero-wait instance: write then read of the same word back to back, data forwarded.
    do_reset();
    drive(1'b1, T_NONSEQ, 1'b1, 32'h8000_0008, 32'h0);
    step();
    check_bus("ws0_write", 1'b1, 1'b1, 2'b00, 32'h0);
    drive(1'b1, T_NONSEQ, 1'b0, 32'h8000_0008, 32'hA5A5_0001);
    step();
    check_bus("ws0_fwd_read", 1'b1, 1'b1, 2'b00, 32'hA5A5_0001);
    drive(1'b1, T_NONSEQ, 1'b0, 32'h8000_0008, 32'h0);
    step();
    check_bus("ws0_reread", 1'b1, 1'b1, 2'b00, 32'hA5A5_0001);
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'h0);
    step();
    check_bus("ws0_idle", 1'b1, 1'b1, 2'b00, 32'h0);

    // Reset clears storage: the word written in the table run now reads as zero.
    do_reset();
    drive(1'b1, T_NONSEQ, 1'b0, 32'h8000_0004, 32'h0);
    step();
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'h0);
    step();
    check_bus("mem_cleared", 1'b0, 1'b1, 2'b00, 32'h0);

    // Reset during the WAIT of a write aborts it without touching the target word.
    drive(1'b1, T_NONSEQ, 1'b1, 32'h8000_0010, 32'h0);
    step();
    check_bus("abort_wait", 1'b0, 1'b0, 2'b00, 32'h0);
    HRESET = 1'b1;
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'hFFFF_FFFF);
    step();
    check_bus("abort_reset", 1'b0, 1'b1, 2'b00, 32'h0);
    HRESET = 1'b0;
    drive(1'b1, T_NONSEQ, 1'b0, 32'h8000_0010, 32'h0);
    step();
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'h0);
    step();
    check_bus("abort_readback", 1'b0, 1'b1, 2'b00, 32'h0);

    // Reset during the DATA cycle of a write also suppresses the write.
    drive(1'b1, T_NONSEQ, 1'b1, 32'h8000_0014, 32'h0);
    step();
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'h7777_7777);
    step();
    check_bus("abort2_data", 1'b0, 1'b1, 2'b00, 32'h0);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    drive(1'b1, T_NONSEQ, 1'b0, 32'h8000_0014, 32'h0);
    step();
    drive(1'b1, T_IDLE, 1'b0, 32'h0, 32'h0);
    step();
    check_bus("abort2_readback", 1'b0, 1'b1, 2'b00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
